// File: rtl/parallax_pkg.sv
// Shared timing defaults, derived sync windows and scroll-speed type for the
// parallax scan-out controller.
package parallax_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 24;
    localparam int DEF_H_SYNC   = 40;
    localparam int DEF_H_BP     = 128;

    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 9;
    localparam int DEF_V_SYNC   = 3;
    localparam int DEF_V_BP     = 28;

    localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + DEF_H_SYNC;
    localparam int V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + DEF_V_SYNC;

    localparam int RGB_W   = 3;
    localparam int SPEED_W = 4;

    typedef logic signed [SPEED_W-1:0] speed_t;

endpackage

// File: rtl/vga_sync_gen.sv
// Raster counters plus visible/vblank and active-low sync decode; the decodes
// are combinational from the counters so the parent can register them together.
module vga_sync_gen
    import parallax_pkg::*;
#(
    parameter int XW       = 10,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic          clk_i,
    input  logic          rst_i,
    output logic [XW-1:0] x_o,
    output logic [XW-1:0] y_o,
    output logic          visible_o,
    output logic          vblank_o,
    output logic          hsync_n_o,
    output logic          vsync_n_o
);

    localparam logic [XW-1:0] H_LAST   = XW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [XW-1:0] V_LAST   = XW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [XW-1:0] H_VIS    = XW'(H_ACTIVE);
    localparam logic [XW-1:0] V_VIS    = XW'(V_ACTIVE);
    localparam logic [XW-1:0] HS_START = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [XW-1:0] VS_START = XW'(V_ACTIVE + V_FP);
    localparam logic [XW-1:0] VS_END   = XW'(V_ACTIVE + V_FP + V_SYNC);

    logic [XW-1:0] x_q, x_d;
    logic [XW-1:0] y_q, y_d;

    always_comb begin
        x_d = x_q + 1'b1;
        y_d = y_q;
        if (x_q == H_LAST) begin
            x_d = '0;
            y_d = (y_q == V_LAST) ? '0 : y_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_o       = x_q;
    assign y_o       = y_q;
    assign visible_o = (x_q < H_VIS) && (y_q < V_VIS);
    assign vblank_o  = (y_q >= V_VIS);
    assign hsync_n_o = !((x_q >= HS_START) && (x_q < HS_END));
    assign vsync_n_o = !((y_q >= VS_START) && (y_q < VS_END));

endmodule

// File: rtl/parallax_scan_ctrl.sv
// Parallax scan-out: per-layer scroll/speed registers, speed-write handshake
// and priority pixel mux. PARALLAX_BG_PATTERN_EN selects a checker background.
module parallax_scan_ctrl
    import parallax_pkg::*;
#(
    parameter int LAYERS   = 4,
    parameter int XW       = 10,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    localparam int LW      = (LAYERS > 1) ? $clog2(LAYERS) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           cfg_valid,
    output logic                           cfg_ready,
    input  logic [LW-1:0]                  cfg_layer,
    input  logic [SPEED_W-1:0]             cfg_speed,
    input  logic [LAYERS-1:0][RGB_W-1:0]   layer_rgb,
    input  logic [LAYERS-1:0]              layer_opaque,
    output logic [XW-1:0]                  x,
    output logic [XW-1:0]                  y,
    output logic [LAYERS-1:0][XW-1:0]      layer_x,
    output logic                           vblank,
    output logic [7:0]                     frame,
    output logic                           hsync,
    output logic                           vsync,
    output logic [RGB_W-1:0]               rgb
);

    logic visible, hsync_n, vsync_n;

    vga_sync_gen #(
        .XW(XW),
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_sync (
        .clk_i     (clk),
        .rst_i     (reset),
        .x_o       (x),
        .y_o       (y),
        .visible_o (visible),
        .vblank_o  (vblank),
        .hsync_n_o (hsync_n),
        .vsync_n_o (vsync_n)
    );

    speed_t [LAYERS-1:0]          speed_q, speed_d;
    speed_t [LAYERS-1:0]          pending_q, pending_d;
    logic   [LAYERS-1:0][XW-1:0]  scroll_q, scroll_d;
    logic   [7:0]                 frame_q, frame_d;
    logic                         hsync_q, vsync_q;
    logic   [RGB_W-1:0]           rgb_q, rgb_d;
    logic   [RGB_W-1:0]           bg, pix;
    logic                         commit, cfg_fire;

    // Frame commit happens on the first vblank pixel; writes stall for that one cycle.
    assign commit    = (x == '0) && (y == XW'(V_ACTIVE));
    assign cfg_ready = !commit;
    assign cfg_fire  = cfg_valid && cfg_ready;

    always_comb begin
        pending_d = pending_q;
        speed_d   = speed_q;
        scroll_d  = scroll_q;
        frame_d   = frame_q;
        if (cfg_fire && (int'(cfg_layer) < LAYERS))
            pending_d[cfg_layer] = speed_t'(cfg_speed);
        if (commit) begin
            for (int i = 0; i < LAYERS; i++) begin
                // Scroll moves by the speed that was live during this frame, not the new one.
                scroll_d[i] = scroll_q[i] + XW'($signed(speed_q[i]));
                speed_d[i]  = pending_q[i];
            end
            frame_d = frame_q + 8'd1;
        end
    end

    for (genvar g = 0; g < LAYERS; g++) begin : g_layer_x
        assign layer_x[g] = x + scroll_q[g];
    end

`ifdef PARALLAX_BG_PATTERN_EN
    assign bg = {x[5] ^ y[5], x[6], y[6]};
`else
    assign bg = '0;
`endif

    always_comb begin
        pix = bg;
        for (int i = LAYERS - 1; i >= 0; i--)
            if (layer_opaque[i]) pix = layer_rgb[i];
        rgb_d = visible ? pix : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= '0;
            speed_q   <= '0;
            scroll_q  <= '0;
            frame_q   <= '0;
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
            rgb_q     <= '0;
        end else begin
            pending_q <= pending_d;
            speed_q   <= speed_d;
            scroll_q  <= scroll_d;
            frame_q   <= frame_d;
            hsync_q   <= hsync_n;
            vsync_q   <= vsync_n;
            rgb_q     <= rgb_d;
        end
    end

    assign frame = frame_q;
    assign hsync = hsync_q;
    assign vsync = vsync_q;
    assign rgb   = rgb_q;

endmodule

// File: tb/tb_parallax_scan_ctrl.sv
// Bench for parallax_scan_ctrl: cycle model from raster time plus directed checks,
// using default horizontal timing and a shortened vertical frame.
module tb_parallax_scan_ctrl;

    localparam int L   = 4;
    localparam int XW  = 10;
    localparam int HA  = 640, HFP = 24, HS = 40, HBP = 128;
    localparam int VA  = 6,   VFP = 2,  VS = 2,  VBP = 2;
    localparam int HT  = HA + HFP + HS + HBP;
    localparam int VT  = VA + VFP + VS + VBP;
    localparam int FR  = HT * VT;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                cfg_valid = 1'b0;
    logic                cfg_ready;
    logic [1:0]          cfg_layer = '0;
    logic [3:0]          cfg_speed = '0;
    logic [L-1:0][2:0]   layer_rgb = '0;
    logic [L-1:0]        layer_opaque = '0;
    logic [XW-1:0]       x, y;
    logic [L-1:0][XW-1:0] layer_x;
    logic                vblank;
    logic [7:0]          frame;
    logic                hsync, vsync;
    logic [2:0]          rgb;

    parallax_scan_ctrl #(
        .LAYERS(L), .XW(XW),
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
    ) dut (
        .clk(clk), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_layer(cfg_layer), .cfg_speed(cfg_speed),
        .layer_rgb(layer_rgb), .layer_opaque(layer_opaque),
        .x(x), .y(y), .layer_x(layer_x), .vblank(vblank), .frame(frame),
        .hsync(hsync), .vsync(vsync), .rgb(rgb)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: raster position is elapsed cycles since reset; registers follow the rules directly.
    int t;
    int m_scroll[L], m_speed[L], m_pend[L];
    int m_frame;
    int e_hs, e_vs, e_rgb;

    function automatic int exp_pixel(input int px, input int py);
        logic [9:0] bx, by;
        bx = 10'(px);
        by = 10'(py);
        if (!(px < HA && py < VA)) return 0;
        for (int i = 0; i < L; i++)
            if (layer_opaque[i]) return int'(layer_rgb[i]);
`ifdef PARALLAX_BG_PATTERN_EN
        return int'({bx[5] ^ by[5], bx[6], by[6]});
`else
        return (bx[0] & by[0] & 1'b0);
`endif
    endfunction

    always @(negedge clk) begin
        int mx, my;
        bit commit;
        if (reset) begin
            t = 0;
            m_frame = 0;
            for (int i = 0; i < L; i++) begin
                m_scroll[i] = 0; m_speed[i] = 0; m_pend[i] = 0;
            end
            e_hs = 1; e_vs = 1; e_rgb = 0;
            chk("rst_x", int'(x), 0);
            chk("rst_y", int'(y), 0);
            chk("rst_hsync", int'(hsync), 1);
            chk("rst_vsync", int'(vsync), 1);
            chk("rst_rgb", int'(rgb), 0);
            chk("rst_vblank", int'(vblank), 0);
            chk("rst_cfg_ready", int'(cfg_ready), 1);
            chk("rst_frame", int'(frame), 0);
        end else begin
            mx = t % HT;
            my = (t / HT) % VT;
            commit = (mx == 0) && (my == VA);
            chk("x", int'(x), mx);
            chk("y", int'(y), my);
            chk("vblank", int'(vblank), (my >= VA) ? 1 : 0);
            chk("cfg_ready", int'(cfg_ready), commit ? 0 : 1);
            chk("frame", int'(frame), m_frame);
            for (int i = 0; i < L; i++)
                chk("layer_x", int'(layer_x[i]), (mx + m_scroll[i]) % 1024);
            chk("hsync", int'(hsync), e_hs);
            chk("vsync", int'(vsync), e_vs);
            chk("rgb", int'(rgb), e_rgb);
            e_hs  = (mx >= HA + HFP && mx < HA + HFP + HS) ? 0 : 1;
            e_vs  = (my >= VA + VFP && my < VA + VFP + VS) ? 0 : 1;
            e_rgb = exp_pixel(mx, my);
            if (cfg_valid && !commit)
                m_pend[cfg_layer] = int'($signed(cfg_speed));
            if (commit) begin
                for (int i = 0; i < L; i++) begin
                    m_scroll[i] = (m_scroll[i] + m_speed[i] + 1024) % 1024;
                    m_speed[i]  = m_pend[i];
                end
                m_frame = (m_frame + 1) % 256;
            end
            t++;
        end
    end

    task automatic wait_xy(input int tx, input int ty);
        int k;
        k = 0;
        @(negedge clk);
        while (!(int'(x) == tx && int'(y) == ty) && k < 2 * FR) begin
            @(negedge clk);
            k++;
        end
        if (k >= 2 * FR) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_xy: position (%0d,%0d) not reached, at (%0d,%0d)", tx, ty, x, y);
        end
    endtask

    task automatic cfg_write(input logic [1:0] l, input logic [3:0] s);
        @(posedge clk);
        #1 cfg_valid = 1'b1; cfg_layer = l; cfg_speed = s;
        @(posedge clk);
        #1 cfg_valid = 1'b0;
    endtask

    initial begin
        int lo, first;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        cfg_write(2'd0, 4'd3);

        // One full line: 40 low clocks, first seen one cycle after x=664.
        wait_xy(0, 1);
        lo = 0; first = -1;
        for (int k = 0; k < HT; k++) begin
            if (!hsync) begin
                lo++;
                if (first < 0) first = int'(x);
            end
            @(negedge clk);
        end
        chk("hsync_low_clocks", lo, 40);
        chk("hsync_first_x", first, 665);

        wait_xy(0, 0);
        chk("frame1_count", int'(frame), 1);
        chk("layer_x0_frame1", int'(layer_x[0]), 0);
        lo = 0; first = -1;
        for (int ln = 0; ln < VT; ln++) begin
            @(negedge clk);
            if (!vsync) begin
                lo++;
                if (first < 0) first = ln;
            end
            repeat (HT - 1) @(negedge clk);
        end
        chk("vsync_low_lines", lo, 2);
        chk("vsync_first_line", first, VA + VFP);
        chk("frame2_count", int'(frame), 2);
        chk("layer_x0_frame2", int'(layer_x[0]), 3);

        @(posedge clk);
        #1 layer_opaque = 4'b0110;
        layer_rgb = {3'b010, 3'b011, 3'b101, 3'b111};
        wait_xy(101, 3);
        chk("rgb_priority_visible", int'(rgb), 5);
        wait_xy(701, 3);
        chk("rgb_hblank", int'(rgb), 0);

        // Asynchronous reset in the middle of a line.
        wait_xy(300, 3);
        #1 reset = 1'b1;
        #1;
        chk("async_rst_x", int'(x), 0);
        chk("async_rst_y", int'(y), 0);
        chk("async_rst_hsync", int'(hsync), 1);
        chk("async_rst_vsync", int'(vsync), 1);
        chk("async_rst_rgb", int'(rgb), 0);
        chk("async_rst_cfg_ready", int'(cfg_ready), 1);
        chk("async_rst_layer_x0", int'(layer_x[0]), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("post_rst_x", int'(x), 0);
        chk("post_rst_y", int'(y), 0);

        cfg_write(2'd1, 4'hF);

        // Write presented exactly on the commit cycle must stall one cycle.
        wait_xy(HT - 1, VA - 1);
        @(posedge clk);
        #1 cfg_valid = 1'b1; cfg_layer = 2'd2; cfg_speed = 4'd5;
        @(negedge clk);
        chk("commit_cycle_y", int'(y), VA);
        chk("ready_commit_cycle", int'(cfg_ready), 0);
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_commit", int'(cfg_ready), 1);
        @(posedge clk);
        #1 cfg_valid = 1'b0;

        wait_xy(0, 0);
        chk("layer_x1_frame1", int'(layer_x[1]), 0);
        wait_xy(0, 0);
        chk("layer_x1_wrap", int'(layer_x[1]), 1023);
        chk("layer_x2_frame2", int'(layer_x[2]), 0);
        wait_xy(0, 0);
        chk("layer_x2_frame3", int'(layer_x[2]), 5);
        chk("layer_x1_frame3", int'(layer_x[1]), 1022);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
